alu_exec_g7: RTL and testbench

- Multi-cycle execute unit that consumes the 4-bit ALUControl code produced by the ALU control decoder. It performs the selected operation on two operands and returns a registered result.
- Operand input and result output each use a valid/ready handshake.
- ADD, SUB, AND and OR complete in one cycle. SRL is iterative, shifting one bit per cycle.
- Sits in the EX stage, between operand select and the writeback/branch logic. The zero flag drives the BEQ decision.

---
 rtl/alu_exec_g7.sv | 121 ++++++++++++
 tb/tb_alu_exec_g7.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_g7.sv
// EX-stage execute unit: single-cycle ADD/SUB/AND/OR, iterative one-bit-per-cycle SRL,
// valid/ready on both sides, registered result with zero/illegal flags.
module alu_exec_g7 #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         ALUControl,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               illegal
);

   // ALUControl encodings shared with the ALU control decoder
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 illegal_q, illegal_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      unique case (state_q)
         S_IDLE: begin
            // flush wins over a same-edge accept
            if (!flush && in_valid) begin
               illegal_d = 1'b0;
               state_d   = S_DONE;
               unique case (ALUControl)
                  ALU_ADD: result_d = a + b;
                  ALU_SUB: result_d = a - b;
                  ALU_AND: result_d = a & b;
                  ALU_OR:  result_d = a | b;
                  ALU_SRL: begin
                     acc_d = a;
                     cnt_d = b[SHAMT_W-1:0];
                     if (b[SHAMT_W-1:0] == '0) result_d = a;
                     else                      state_d  = S_SHIFT;
                  end
                  default: begin
                     result_d  = '0;
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end
         S_SHIFT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_q >> 1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) begin
                  result_d = acc_q >> 1;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (flush || out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // result only changes on completion, so zero tracks it unconditionally
      zero_d      = (result_d == '0);
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_g7.sv
// Bench for alu_exec_g7: vector table through a scoreboard, plus stall, flush and reset sequences.
module tb_alu_exec_g7;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_BAD = 4'b1111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  ALUControl = OP_ADD;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   alu_exec_g7 #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .a(a), .b(b), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        il;
   } exp_t;

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        il;
      int          lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vt[11];
   int   n_vec = 0;
   int   n_err = 0;
   int   lat;
   bit   irdy_bad;
   bit   ov_seen;
   logic [31:0] last_res;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: a result is taken only on out_valid && out_ready && !flush
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("zero", zero, mon_e.z);
            check("illegal", illegal, mon_e.il);
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge
   task automatic issue(input logic [3:0] c, input logic [31:0] aa, input logic [31:0] bb,
                        input bit track, input logic [31:0] er, input logic ez, input logic ei);
      exp_t e;
      ALUControl = c; a = aa; b = bb; in_valid = 1'b1;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      e.res = er; e.z = ez; e.il = ei;
      if (track) sb.push_back(e);
      #1;
      in_valid = 1'b0;
      ALUControl = 4'hA;
      a = $urandom;
      b = $urandom;
   endtask

   // Latency in edges from the accept edge to the first negedge with out_valid
   task automatic wait_out(output int l);
      l = 1;
      irdy_bad = 1'b0;
      @(negedge clk);
      while (!out_valid && l < 40) begin
         if (in_ready) irdy_bad = 1'b1;
         @(negedge clk);
         l++;
      end
      if (in_ready) irdy_bad = 1'b1;
   endtask

   initial begin
      vt[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,        32'h0,         1'b1, 1'b0, 1};
      vt[1]  = '{OP_SUB, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      vt[2]  = '{OP_OR,  32'hF0,        32'h0F,       32'hFF,        1'b0, 1'b0, 1};
      vt[3]  = '{OP_AND, 32'hF0,        32'h0F,       32'h0,         1'b1, 1'b0, 1};
      vt[4]  = '{OP_SRL, 32'h8000_0000, 32'd31,       32'h1,         1'b0, 1'b0, 32};
      vt[5]  = '{OP_SRL, 32'h8000_0000, 32'h20,       32'h8000_0000, 1'b0, 1'b0, 1};
      vt[6]  = '{OP_BAD, 32'd3,         32'd4,        32'h0,         1'b1, 1'b1, 1};
      vt[7]  = '{OP_ADD, 32'd3,         32'd4,        32'h7,         1'b0, 1'b0, 1};
      vt[8]  = '{OP_SRL, 32'hF0,        32'd4,        32'hF,         1'b0, 1'b0, 5};
      vt[9]  = '{OP_SUB, 32'd7,         32'd7,        32'h0,         1'b1, 1'b0, 1};
      vt[10] = '{OP_SRL, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'h7FFF_FFFF, 1'b0, 1'b0, 2};

      // reset values while rst is held
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_illegal", illegal, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         issue(vt[i].c, vt[i].a, vt[i].b, 1'b1, vt[i].res, vt[i].z, vt[i].il);
         wait_out(lat);
         check($sformatf("latency_v%0d", i), lat, vt[i].lat);
         check($sformatf("in_ready_busy_v%0d", i), irdy_bad, 0);
         last_res = vt[i].res;
         @(posedge clk); #1;
      end

      // backpressure: result held, new request ignored while stalled
      out_ready = 1'b0;
      issue(OP_AND, 32'hFF, 32'h0F, 1'b1, 32'h0F, 1'b0, 1'b0);
      wait_out(lat);
      check("stall_latency", lat, 1);
      @(posedge clk); #1;
      in_valid = 1'b1; ALUControl = OP_ADD; a = 32'd1; b = 32'd1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_out_valid", out_valid, 1);
         check("stall_result", result, 32'h0F);
         check("stall_zero", zero, 0);
         check("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_drained_ov", out_valid, 0);
      check("stall_drained_ir", in_ready, 1);
      check("stall_sb_empty", sb.size(), 0);
      last_res = 32'h0F;
      @(posedge clk); #1;

      // flush during SHIFT, sampled on the 5th edge counting the accept edge
      issue(OP_SRL, 32'hFFFF_FFFF, 32'd20, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush_shift_ov", out_valid, 0);
      check("flush_shift_ir", in_ready, 1);
      check("flush_shift_result", result, last_res);
      ov_seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      check("flush_shift_no_ov", ov_seen, 0);
      @(posedge clk); #1;

      // flush in IDLE blocks a same-edge accept
      in_valid = 1'b1; ALUControl = OP_ADD; a = 32'd1; b = 32'd2; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_idle_ir", in_ready, 1);
      check("flush_idle_ov", out_valid, 0);
      check("flush_idle_result", result, last_res);
      @(posedge clk); #1;

      // flush together with out_ready in DONE: dropped, not consumed
      out_ready = 1'b0;
      issue(OP_OR, 32'd1, 32'd2, 1'b0, '0, 1'b0, 1'b0);
      wait_out(lat);
      check("flush_done_latency", lat, 1);
      check("flush_done_pre_result", result, 32'd3);
      @(posedge clk); #1;
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush_done_ov", out_valid, 0);
      check("flush_done_ir", in_ready, 1);
      check("flush_done_result", result, 32'd3);
      @(posedge clk); #1;

      // asynchronous reset mid-shift
      issue(OP_SRL, 32'hFFFF_FFFF, 32'd20, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_result", result, 0);
      check("arst_zero", zero, 1);
      check("arst_illegal", illegal, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      issue(OP_ADD, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0);
      wait_out(lat);
      check("post_rst_latency", lat, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
